// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: ALU opcodes, LEGv8
// instruction opcode fields and the issue FSM state encoding.
package alu_ctrl_pkg;

   // 4-bit opcodes understood by the combinational ALU
   localparam logic [3:0] ALU_NOP  = 4'b0000;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_ORR  = 4'b0100;
   localparam logic [3:0] ALU_AND  = 4'b0110;
   localparam logic [3:0] ALU_CBZ  = 4'b0111;
   localparam logic [3:0] ALU_EOR  = 4'b1001;
   localparam logic [3:0] ALU_SUB  = 4'b1010;
   localparam logic [3:0] ALU_NOR  = 4'b1100;
   localparam logic [3:0] ALU_MOV  = 4'b1101;
   localparam logic [3:0] ALU_NAND = 4'b1110;

   // LEGv8 opcode fields: R/D-format in [31:21], CB in [31:24], IW in [31:23]
   localparam logic [10:0] OPC_ADD  = 11'b10001011000;
   localparam logic [10:0] OPC_SUB  = 11'b11001011000;
   localparam logic [10:0] OPC_AND  = 11'b10001010000;
   localparam logic [10:0] OPC_ORR  = 11'b10101010000;
   localparam logic [10:0] OPC_EOR  = 11'b11001010000;
   localparam logic [10:0] OPC_LDUR = 11'b11111000010;
   localparam logic [10:0] OPC_STUR = 11'b11111000000;
   localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
   localparam logic [8:0]  OPC_MOVZ = 9'b110100101;

   // Issue FSM states; encoding is fixed so checkers can bind to it
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      HOLD = 2'd2
   } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational LEGv8 -> ALU opcode decoder. First matching field wins;
// unmatched words yield ALU_NOP with the illegal flag set.
module alu_op_decode
   import alu_ctrl_pkg::*;
(
   input  logic [31:0] in_instr,
   output logic [3:0]  alu_opcode,
   output logic        illegal,
   output logic        is_cbz
);

   // Operand/immediate fields are not needed for opcode selection
   logic unused_fields;
   assign unused_fields = ^in_instr[20:0];

   // Priority decode of the opcode fields
   always_comb begin
      alu_opcode = ALU_NOP;
      illegal    = 1'b0;
      is_cbz     = 1'b0;
      if (in_instr[31:21] == OPC_ADD) begin
         alu_opcode = ALU_ADD;
      end else if (in_instr[31:21] == OPC_SUB) begin
         alu_opcode = ALU_SUB;
      end else if (in_instr[31:21] == OPC_AND) begin
         alu_opcode = ALU_AND;
      end else if (in_instr[31:21] == OPC_ORR) begin
         alu_opcode = ALU_ORR;
      end else if (in_instr[31:21] == OPC_EOR) begin
         alu_opcode = ALU_EOR;
      end else if ((in_instr[31:21] == OPC_LDUR) || (in_instr[31:21] == OPC_STUR)) begin
         alu_opcode = ALU_ADD;
      end else if (in_instr[31:24] == OPC_CBZ) begin
         alu_opcode = ALU_CBZ;
         is_cbz     = 1'b1;
      end else if (in_instr[31:23] == OPC_MOVZ) begin
         alu_opcode = ALU_MOV;
      end else begin
         illegal    = 1'b1;
      end
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: accepts an instruction plus operands (valid/ready),
// drives registered opcode/operands to the combinational ALU, captures the
// result and returns it with zero/branch/illegal flags (valid/ready).
// Optional performance counters: define ALU_ISSUE_CTRL_PERF_EN.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid, once raised, holds with stable payload until that edge.
// in_ready and out_valid decode the registered state only, so neither
// depends combinationally on the opposite side of the block.
module alu_issue_ctrl
   import alu_ctrl_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int PERF_W = 16
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_instr,
   input  logic [DATA_W-1:0] in_op1,
   input  logic [DATA_W-1:0] in_op2,
   output logic [3:0]        alu_opcode,
   output logic [DATA_W-1:0] alu_in1,
   output logic [DATA_W-1:0] alu_in2,
   input  logic [DATA_W-1:0] alu_result,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic              out_zero,
   output logic              out_branch,
   output logic              out_illegal,
   output logic [PERF_W-1:0] perf_issued,
   output logic [PERF_W-1:0] perf_illegal
);

   state_t      state;
   state_t      state_nxt;
   logic        load_in;
   logic        capture_res;
   logic [3:0]  dec_opcode;
   logic        dec_illegal;
   logic        dec_cbz;
   logic        illegal_q;
   logic        cbz_q;

   alu_op_decode u_dec (
      .in_instr   (in_instr),
      .alu_opcode (dec_opcode),
      .illegal    (dec_illegal),
      .is_cbz     (dec_cbz)
   );

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic and load/capture strobes
   always_comb begin
      state_nxt   = state;
      load_in     = 1'b0;
      capture_res = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid) begin
               load_in   = 1'b1;
               state_nxt = EXEC;
            end
         end
         EXEC: begin
            capture_res = 1'b1;
            state_nxt   = HOLD;
         end
         HOLD: begin
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == HOLD);

   // Latch decoded opcode and operands at acceptance; held afterwards
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_opcode <= ALU_NOP;
         alu_in1    <= '0;
         alu_in2    <= '0;
         illegal_q  <= 1'b0;
         cbz_q      <= 1'b0;
      end else if (load_in) begin
         alu_opcode <= dec_opcode;
         alu_in1    <= in_op1;
         alu_in2    <= in_op2;
         illegal_q  <= dec_illegal;
         cbz_q      <= dec_cbz;
      end
   end

   // Capture the settled ALU result and its flags at the end of EXEC
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_result  <= '0;
         out_zero    <= 1'b0;
         out_branch  <= 1'b0;
         out_illegal <= 1'b0;
      end else if (capture_res) begin
         out_result  <= alu_result;
         out_zero    <= (alu_result == '0);
         out_branch  <= cbz_q && (alu_result == DATA_W'(1));
         out_illegal <= illegal_q;
      end
   end

`ifdef ALU_ISSUE_CTRL_PERF_EN
   // Completion counters, wrapping naturally at 2^PERF_W
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_issued  <= '0;
         perf_illegal <= '0;
      end else if (out_valid && out_ready) begin
         perf_issued <= perf_issued + 1'b1;
         if (out_illegal) perf_illegal <= perf_illegal + 1'b1;
      end
   end
`else
   assign perf_issued  = '0;
   assign perf_illegal = '0;
`endif

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Front-end sequencer for the ALU. Accepts one LEGv8 instruction word plus two operand values over a valid/ready handshake.
- Decodes the instruction into the 4-bit ALU opcode, drives the registered opcode and operands to the combinational ALU, and captures the ALU result.
- Returns the result, zero/branch/illegal flags downstream over a second valid/ready handshake.
- Sits between register-read and writeback in the single-issue datapath.

Parameters:
- DATA_W, 32: operand/result width; must equal the ALU width.
- PERF_W, 16: width of the performance counters (used only with the optional feature).

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  instruction/operands valid
- in_ready  out  1  block can accept
- in_instr  in  32  LEGv8 instruction word
- in_op1  in  DATA_W  first operand (Rn value)
- in_op2  in  DATA_W  second operand (Rm value, or pre-extended immediate)
- alu_opcode  out  4  opcode driven to ALU
- alu_in1  out  DATA_W  ALU operand 1
- alu_in2  out  DATA_W  ALU operand 2
- alu_result  in  DATA_W  combinational ALU result
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- out_result  out  DATA_W  captured ALU result
- out_zero  out  1  out_result == 0
- out_branch  out  1  CBZ taken (CBZ decoded and alu_result == 1)
- out_illegal  out  1  instruction did not decode
- perf_issued  out  PERF_W  instructions completed (optional feature)
- perf_illegal  out  PERF_W  illegal instructions completed (optional feature)

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, in_ready=1, out_valid=0.
  - alu_opcode=4'b0000, alu_in1=0, alu_in2=0.
  - out_result=0, out_zero=0, out_branch=0, out_illegal=0, perf counters=0.
- Decode from in_instr, first match wins:
  - [31:21]=10001011000 ADD -> 0010
  - [31:21]=11001011000 SUB -> 1010
  - [31:21]=10001010000 AND -> 0110
  - [31:21]=10101010000 ORR -> 0100
  - [31:21]=11001010000 EOR -> 1001
  - [31:21]=11111000010 LDUR or 11111000000 STUR -> 0010
  - [31:24]=10110100 CBZ -> 0111
  - [31:23]=110100101 MOVZ -> 1101
  - anything else -> 0000, illegal=1.
- FSM (encoding fixed):
  - IDLE: in_ready=1. On in_valid: latch the decoded opcode into alu_opcode, in_op1 into alu_in1, in_op2 into alu_in2, latch the illegal and is_cbz flags; go to EXEC.
  - EXEC: in_ready=0; ALU settles combinationally. At the clock edge, capture out_result=alu_result, out_zero=(alu_result==0), out_branch=is_cbz & (alu_result==1), out_illegal; set out_valid=1; go to HOLD.
  - HOLD: out_valid=1; outputs stable. If out_ready, clear out_valid and go to IDLE. Otherwise stay.
- Latency: acceptance edge -> out_valid high after 2 edges. Peak throughput is 1 per 3 cycles.
- in_ready is a registered-state decode, not combinationally dependent on out_ready. No new acceptance occurs in the HOLD->IDLE transition cycle.
- alu_opcode/alu_in1/alu_in2 hold their last values after completion; they are not zeroed.
- Illegal instruction: still goes through EXEC/HOLD. The ALU's default yields 0, so out_result=0, out_zero=1, out_illegal=1.
- Width rule: no extension is done here; operands pass unmodified.
- Reset mid-operation: in-flight transaction dropped, all outputs return to reset values immediately.
- in_valid with X/changing data outside IDLE is ignored.

Optional Feature:
- Macro ALU_ISSUE_CTRL_PERF_EN.
- Defined:
  - perf_issued increments on each HOLD completion (out_valid & out_ready).
  - perf_illegal increments on completions with out_illegal=1.
  - Both wrap modulo 2^PERF_W and reset to 0.
- Undefined: both ports tied to 0, no counter flops.

Decomposition:
- Package alu_ctrl_pkg:
  - ALU opcode localparams (ADD, CBZ, SUB, AND, ORR, EOR, NOR, NAND, MOV).
  - LEGv8 instruction opcode-field localparams.
  - FSM state encoding: IDLE=2'd0, EXEC=2'd1, HOLD=2'd2.
- Sub-module alu_op_decode: purely combinational; in_instr -> {alu_opcode, illegal, is_cbz}. Instantiated once; unit-testable alone.

Test Plan:
- ADD: instr 0x8B020020, op1=15, op2=15 -> alu_opcode=0010, out_result=30, out_valid 2 cycles after accept, out_zero=0.
- CBZ: instr 0xB4000040, op1=0 -> alu_opcode=0111, out_result=1, out_branch=1. Repeat with op1=10 -> out_result=0, out_branch=0, out_zero=1.
- SUB with backpressure: instr 0xCB020020, op1=10, op2=15, out_ready=0 for 5 cycles -> out_result=0xFFFFFFFB held stable, in_ready=0 throughout; completes on out_ready=1, then in_ready=1.
- Illegal: instr 0x00000000 -> alu_opcode=0000, out_illegal=1, out_result=0, out_zero=1. With the perf feature: perf_illegal=1, perf_issued=1.
- Reset mid-EXEC: assert rst asynchronously between clock edges -> out_valid=0, in_ready=1, alu_opcode=0000 immediately. After release, a new EOR (0xCA020020, op1=5, op2=10) yields 15.
- Back-to-back: MOVZ (0xD2800000 class, op1=7) then ORR (0xAA020020, op1=5, op2=10) with out_ready=1 -> results 7 and 15, 3-cycle spacing, no lost transaction.
